// File: rtl/alu_seq_core.sv
// -----------------------------------------------------------------------------
// alu_seq_core
//
// Purpose:
//    This is the operand-consuming end of the ALU stimulus interface. In IDLE,
//    an Enable strobe captures two operands and an opcode. The core then runs
//    the operation and returns a registered result with a carry/borrow/overflow
//    flag.
//    - Logic ops, PASS, NOT, ADD, SUB and unused opcodes finish in one cycle.
//    - Shifts move one bit per cycle.
//    - MUL is a 16-step unsigned shift-and-add.
//    - Done pulses for one cycle when Results/CF update.
//    - Busy is high while an accepted operation is in flight.
//
// Ports:
//    CLK      in   1      single clock, rising edge
//    RST      in   1      synchronous active-low reset
//    Enable   in   1      operation request, sampled only in IDLE
//    Data_A   in   WIDTH  operand A
//    Data_B   in   WIDTH  operand B (B[3:0] is the shift count for shifts)
//    Opcode   in   4      operation select
//    Results  out  WIDTH  registered result, held until the next completion
//    CF       out  1      registered carry / borrow / overflow flag
//    Done     out  1      one-cycle completion pulse
//    Busy     out  1      operation in flight
//
// WIDTH is a parameter for readability only; the only supported value is 16.
// -----------------------------------------------------------------------------
module alu_seq_core #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Enable,
   input  logic [WIDTH-1:0] Data_A,
   input  logic [WIDTH-1:0] Data_B,
   input  logic [3:0]       Opcode,
   output logic [WIDTH-1:0] Results,
   output logic             CF,
   output logic             Done,
   output logic             Busy
);

   // Shift counts and the MUL iteration counter both fit in log2(WIDTH) bits.
   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  MUL_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_ITER
   } state_e;

   // Encodings 4'hA..4'hF are not listed. They fall through to the
   // default case, which gives a zero result and a zero flag.
   typedef enum logic [3:0] {
      OP_PASS = 4'h0,
      OP_ADD  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_SUB  = 4'h5,
      OP_NOT  = 4'h6,
      OP_SHL  = 4'h7,
      OP_SHR  = 4'h8,
      OP_MUL  = 4'h9
   } op_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e               state_q;

   // Operands and opcode latched at acceptance. Later input changes are not
   // seen by the operation.
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [3:0]           op_q;

   // Iterative datapath.
   logic [WIDTH-1:0]     sh_q;        // shift operand, moved one bit per cycle
   logic [2*WIDTH-1:0]   mcand_q;     // multiplicand, doubles every step
   logic [WIDTH-1:0]     mplier_q;    // multiplier, LSB selects the next add
   logic [2*WIDTH-1:0]   prod_q;      // partial product
   logic [CNT_W-1:0]     cnt_q;       // shift steps left, or MUL steps left - 1

   // Registered outputs.
   logic [WIDTH-1:0]     res_q;
   logic                 cf_q;
   logic                 done_q;
   logic                 busy_q;

   // ---------------------------------------------------------------------------
   // Next-value logic
   // ---------------------------------------------------------------------------
   logic [WIDTH:0]       sum_d;
   logic [WIDTH:0]       diff_d;
   logic [WIDTH-1:0]     exec_res_d;
   logic                 exec_cf_d;

   logic                 sh_left_d;
   logic [WIDTH-1:0]     sh_nx_d;
   logic                 sh_out_d;
   logic [2*WIDTH-1:0]   prod_d;

   logic                 iter_done_d;
   logic [WIDTH-1:0]     iter_res_d;
   logic                 iter_cf_d;

   logic                 accept_iter_d;

   // Single-cycle results, computed from the latched operands.
   always_comb begin
      // NOTE: every output of this block gets a default before the case so no
      // path leaves a signal unassigned, which would infer a latch.
      exec_res_d = '0;
      exec_cf_d  = 1'b0;

      sum_d  = {1'b0, a_q} + {1'b0, b_q};
      // A 17-bit subtract wraps when A < B. The MSB is then the unsigned borrow.
      diff_d = {1'b0, a_q} - {1'b0, b_q};

      case (op_q)
         OP_PASS: exec_res_d = a_q;
         OP_ADD: begin
            exec_res_d = sum_d[WIDTH-1:0];
            exec_cf_d  = sum_d[WIDTH];
         end
         OP_AND:  exec_res_d = a_q & b_q;
         OP_OR:   exec_res_d = a_q | b_q;
         OP_XOR:  exec_res_d = a_q ^ b_q;
         OP_SUB: begin
            exec_res_d = diff_d[WIDTH-1:0];
            exec_cf_d  = diff_d[WIDTH];
         end
         OP_NOT:  exec_res_d = ~a_q;
         default: begin
            exec_res_d = '0;
            exec_cf_d  = 1'b0;
         end
      endcase
   end

   // Iterative step and completion detection.
   always_comb begin
      sh_left_d = (op_q == OP_SHL);

      if (sh_left_d) begin
         sh_nx_d  = {sh_q[WIDTH-2:0], 1'b0};
         sh_out_d = sh_q[WIDTH-1];
      end else begin
         sh_nx_d  = {1'b0, sh_q[WIDTH-1:1]};
         sh_out_d = sh_q[0];
      end

      prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);

      iter_done_d = 1'b0;
      iter_res_d  = '0;
      iter_cf_d   = 1'b0;

      if (op_q == OP_MUL) begin
         // The counter starts at WIDTH-1, so the step taken at count 0 is the
         // WIDTH-th and final add.
         iter_done_d = (cnt_q == '0);
         iter_res_d  = prod_d[WIDTH-1:0];
         iter_cf_d   = |prod_d[2*WIDTH-1:WIDTH];
      end else if (cnt_q == '0) begin
         // A zero-count shift still takes one cycle. It returns A unchanged
         // with no carry.
         iter_done_d = 1'b1;
         iter_res_d  = sh_q;
         iter_cf_d   = 1'b0;
      end else if (cnt_q == CNT_ONE) begin
         // Last shift step. CF is the bit shifted out on this step.
         iter_done_d = 1'b1;
         iter_res_d  = sh_nx_d;
         iter_cf_d   = sh_out_d;
      end
   end

   assign accept_iter_d = (Opcode == OP_SHL) || (Opcode == OP_SHR) ||
                          (Opcode == OP_MUL);

   // ---------------------------------------------------------------------------
   // Controller and registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RST) begin
         // NOTE: all state is written with non-blocking assignments. Every
         // register then samples values from before the edge, whatever the
         // statement order.
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         sh_q     <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         cf_q     <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         // Done is a one-cycle pulse. It is set only in the completing branches.
         done_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (Enable) begin
                  a_q      <= Data_A;
                  b_q      <= Data_B;
                  op_q     <= Opcode;
                  sh_q     <= Data_A;
                  mcand_q  <= {{WIDTH{1'b0}}, Data_A};
                  mplier_q <= Data_B;
                  prod_q   <= '0;
                  busy_q   <= 1'b1;
                  if (accept_iter_d) begin
                     state_q <= S_ITER;
                     cnt_q   <= (Opcode == OP_MUL) ? MUL_LAST
                                                   : Data_B[CNT_W-1:0];
                  end else begin
                     state_q <= S_EXEC;
                  end
               end
            end

            S_EXEC: begin
               res_q   <= exec_res_d;
               cf_q    <= exec_cf_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            S_ITER: begin
               if (iter_done_d) begin
                  res_q   <= iter_res_d;
                  cf_q    <= iter_cf_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  // Both iterative datapaths advance every cycle. Only the one
                  // selected by the latched opcode feeds the result.
                  cnt_q    <= cnt_q - CNT_ONE;
                  sh_q     <= sh_nx_d;
                  prod_q   <= prod_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Results = res_q;
   assign CF      = cf_q;
   assign Done    = done_q;
   assign Busy    = busy_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_core
//
// Self-checking bench for alu_seq_core.
// - Stimulus is driven on the falling edge of CLK. The DUT samples on the
//   rising edge.
// - Each accepted operation that should complete pushes its expected result,
//   flag and completion cycle onto a scoreboard queue.
// - A falling-edge monitor pops one entry for every Done pulse.
// - A Done with an empty queue is an error.
// -----------------------------------------------------------------------------
module tb_alu_seq_core;

   localparam int WIDTH = 16;

   localparam logic [3:0] OP_PASS = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_SHR  = 4'h8;
   localparam logic [3:0] OP_MUL  = 4'h9;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        cf;
      int          lat;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] res;
      logic        cf;
      int          cyc;
   } exp_t;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             Enable = 1'b0;
   logic [WIDTH-1:0] Data_A = '0;
   logic [WIDTH-1:0] Data_B = '0;
   logic [3:0]       Opcode = '0;
   logic [WIDTH-1:0] Results;
   logic             CF;
   logic             Done;
   logic             Busy;

   alu_seq_core #(.WIDTH(WIDTH)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .Enable  (Enable),
      .Data_A  (Data_A),
      .Data_B  (Data_B),
      .Opcode  (Opcode),
      .Results (Results),
      .CF      (CF),
      .Done    (Done),
      .Busy    (Busy)
   );

   always #5 CLK = ~CLK;

   // Rising edges seen so far. At a falling edge, the next rising edge is
   // number cyc+1.
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[$];
   exp_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic add_vec(input string name, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input logic cf, input int lat);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b;
      v.res = res; v.cf = cf; v.lat = lat;
      vecs.push_back(v);
   endtask

   task automatic push_exp(input string name, input logic [15:0] res,
                           input logic cf, input int done_cyc);
      exp_t e;
      e.name = name; e.res = res; e.cf = cf; e.cyc = done_cyc;
      sb_q.push_back(e);
   endtask

   // Presents one operation with a single-cycle Enable. It returns at the
   // falling edge after the accepting rising edge.
   task automatic issue(input string name, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic cf,
                        input int lat, input bit expect_done);
      @(negedge CLK);
      Data_A = a;
      Data_B = b;
      Opcode = op;
      Enable = 1'b1;
      if (expect_done) push_exp(name, res, cf, cyc + 1 + lat);
      @(negedge CLK);
      Enable = 1'b0;
      check({name, "_busy"}, Busy, 1);
   endtask

   // Waits, with a bounded cycle budget, for every expected completion.
   task automatic drain();
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge CLK);
      check("drain", sb_q.size(), 0);
   endtask

   // Scoreboard monitor.
   always @(negedge CLK) begin
      if (Done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", Done, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, "_res"},  Results, e.res);
            check({e.name, "_cf"},   CF,      e.cf);
            check({e.name, "_cyc"},  cyc,     e.cyc);
            check({e.name, "_busy0"}, Busy,   0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // name, op, A, B, expected R, expected CF, latency
      add_vec("carry",    OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1);
      add_vec("borrow",   OP_SUB,  16'd5,    16'd7,    16'hFFFE, 1'b1, 1);
      add_vec("sub_nb",   OP_SUB,  16'd7,    16'd5,    16'h0002, 1'b0, 1);
      add_vec("and",      OP_AND,  16'd6464, 16'd4646, 16'h1000, 1'b0, 1);
      add_vec("or",       OP_OR,   16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1);
      add_vec("xor",      OP_XOR,  16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0, 1);
      add_vec("pass",     OP_PASS, 16'h1234, 16'hFFFF, 16'h1234, 1'b0, 1);
      add_vec("not",      OP_NOT,  16'h1234, 16'h0000, 16'hEDCB, 1'b0, 1);
      add_vec("ill_a",    4'hA,    16'h1234, 16'h5678, 16'h0000, 1'b0, 1);
      add_vec("ill_f",    4'hF,    16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1);
      add_vec("shl1",     OP_SHL,  16'h8001, 16'd1,    16'h0002, 1'b1, 1);
      add_vec("shr4",     OP_SHR,  16'h00F0, 16'd4,    16'h000F, 1'b0, 4);
      add_vec("shl0",     OP_SHL,  16'hABCD, 16'd0,    16'hABCD, 1'b0, 1);
      add_vec("shr2",     OP_SHR,  16'h0003, 16'd2,    16'h0000, 1'b1, 2);
      add_vec("shl15",    OP_SHL,  16'h0003, 16'd15,   16'h8000, 1'b1, 15);
      add_vec("shr_hib",  OP_SHR,  16'h8000, 16'h0011, 16'h4000, 1'b0, 1);
      add_vec("mul_max",  OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 16);
      add_vec("mul_zero", OP_MUL,  16'h0000, 16'h1234, 16'h0000, 1'b0, 16);

      // Reset, then idle with a valid-looking operation on the inputs.
      RST = 1'b0; Enable = 1'b0;
      Data_A = 16'd6464; Data_B = 16'd4646; Opcode = OP_ADD;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         check("idle_busy", Busy, 0);
         check("idle_done", Done, 0);
      end
      check("idle_res", Results, 0);
      check("idle_cf",  CF, 0);

      // First ADD. Results must then hold with no further Done.
      issue("add", OP_ADD, 16'd6464, 16'd4646, 16'h2B66, 1'b0, 1, 1'b1);
      drain();
      Opcode = OP_AND;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         check("hold_res",  Results, 16'd11110);
         check("hold_done", Done, 0);
      end

      // Table of single operations.
      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].cf, vecs[i].lat, 1'b1);
         drain();
      end

      // Enable held for 4 cycles gives two back-to-back single-cycle ops.
      @(negedge CLK);
      Data_A = 16'd1; Data_B = 16'd2; Opcode = OP_ADD; Enable = 1'b1;
      push_exp("held1", 16'd3, 1'b0, cyc + 2);
      push_exp("held2", 16'd3, 1'b0, cyc + 4);
      repeat (4) @(negedge CLK);
      Enable = 1'b0;
      drain();

      // MUL with ADD requests during edges N+3..N+8. The ADD must be ignored.
      issue("mul300", OP_MUL, 16'd300, 16'd300, 16'h5F90, 1'b1, 16, 1'b1);
      repeat (2) @(negedge CLK);
      Data_A = 16'd1; Data_B = 16'd1; Opcode = OP_ADD; Enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         check("mul_busy", Busy, 1);
      end
      Enable = 1'b0;
      drain();
      issue("mul255", OP_MUL, 16'd255, 16'd255, 16'hFE01, 1'b0, 16, 1'b1);
      drain();

      // Reset beats a simultaneous Enable. Enable is honoured on the first
      // edge after reset is released.
      @(negedge CLK);
      RST = 1'b0; Enable = 1'b1;
      Data_A = 16'd2; Data_B = 16'd2; Opcode = OP_ADD;
      @(negedge CLK);
      check("rst_wins_busy", Busy, 0);
      check("rst_wins_res",  Results, 0);
      RST = 1'b1;
      push_exp("post_rst", 16'd4, 1'b0, cyc + 2);
      @(negedge CLK);
      Enable = 1'b0;
      check("post_rst_busy", Busy, 1);
      drain();

      // Reset in the middle of a MUL. That operation must never complete.
      issue("mul_rst", OP_MUL, 16'd300, 16'd300, 16'h5F90, 1'b1, 16, 1'b0);
      repeat (7) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      check("midrst_res",  Results, 0);
      check("midrst_cf",   CF, 0);
      check("midrst_busy", Busy, 0);
      check("midrst_done", Done, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         check("midrst_idle", Busy, 0);
      end
      issue("add12", OP_ADD, 16'd1, 16'd2, 16'd3, 1'b0, 1, 1'b1);
      drain();

      repeat (3) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
